credit_rr_arbiter: RTL and testbench
====================================

# credit_rr_arbiter

Packet-level round-robin arbiter with credit-based flow control that shares the master-side send-request FIFO among several requesting cores. It grants one requester at a time and holds the grant until that requester's tail flit (wormhole style). It writes flits into the send-request FIFO only while downstream credits remain. It owns the credit counter for the request path, decrementing on each write and incrementing on each credit-return pulse from the receiving side.

## Interface
- NUM_REQ, 4, number of requesting cores (2..16)
- DATA_LINE_WIDTH, 40, flit width in bits
- FIFO_DEPTH, 32, downstream receive-FIFO depth; initial and maximum credit count
- LOG2_FIFO_DEPTH, 5, log2(FIFO_DEPTH)
- IDX_W, 2, width of requester index, equal to log2(NUM_REQ)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_req_valid  in  NUM_REQ  per-requester flit valid
- i_req_bits  in  NUM_REQ*DATA_LINE_WIDTH  per-requester flit; requester k occupies bits [k*DATA_LINE_WIDTH +: DATA_LINE_WIDTH]
- i_req_last  in  NUM_REQ  per-requester tail-flit marker, qualified by valid
- o_req_ready  out  NUM_REQ  per-requester flit accept
- o_sreq_inbits  out  DATA_LINE_WIDTH  flit to the send-request FIFO
- o_sreq_wen  out  1  send-request FIFO write enable
- i_sreq_fifo_full  in  1  send-request FIFO full flag
- i_credit_return  in  1  one-cycle pulse per flit drained at the far receive FIFO
- o_credits  out  LOG2_FIFO_DEPTH+1  current credit count
- o_grant  out  NUM_REQ  one-hot current owner; all zeros when idle
- o_busy  out  1  high in the LOCKED state
- o_credit_err  out  1  sticky flag for a credit-return overflow

## Operation
- **State machine:** two states, IDLE and LOCKED.
- **IDLE:**
  - o_grant = 0, o_req_ready = 0, o_sreq_wen = 0.
  - If any i_req_valid bit is set, select the first valid requester searching upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - Register the selection as owner and go to LOCKED on the next edge.
  - Arbitration does not depend on credits or the FIFO full flag.
- **LOCKED:**
  - o_grant = onehot(owner).
  - o_req_ready[owner] = (o_credits != 0) && !i_sreq_fifo_full. All other ready bits are 0.
- **Transfer:** a transfer happens when i_req_valid[owner] && o_req_ready[owner].
  - o_sreq_wen = transfer, combinational.
  - o_sreq_inbits = flit of the owner, combinational mux. It is don't-care when no transfer occurs but must still be driven, never X.
- **End of packet:** a transfer with i_req_last[owner] = 1 returns the FSM to IDLE and sets rr_ptr = owner+1 modulo NUM_REQ.
- **Owner stall:** if the owner deasserts valid mid-packet, the FSM stays in LOCKED. The grant is never revoked before the tail flit.
- **Credits:**
  - next = credits − transfer + i_credit_return.
  - A simultaneous transfer and return leaves the count unchanged.
  - A return while credits == FIFO_DEPTH and no transfer occurs: the count holds at FIFO_DEPTH and o_credit_err is set. o_credit_err stays set until reset.
  - The count can never underflow because ready is gated by credits != 0.
- **Width rule:** credits use LOG2_FIFO_DEPTH+1 bits so that FIFO_DEPTH is representable.

## Timing
- **Reset (async assert, sync release):**
  - State IDLE, owner 0, rr_ptr 0, credits = FIFO_DEPTH, o_credit_err 0.
  - All outputs are 0 except o_credits = FIFO_DEPTH.
  - A reset asserted mid-packet abandons the packet; no partial-packet recovery is performed.
- **Arbitration latency:** valid seen in IDLE at cycle N gives grant at N+1. The first flit can be written in cycle N+1 if credits and space allow.
- **Throughput:** one flit per cycle while in LOCKED. There is exactly one idle (arbitration) cycle between consecutive packets.
- **Zero credits:** ready drops in the same cycle that credits reads 0. A return pulse in cycle M makes credits nonzero at M+1, and a transfer may occur in M+1.
- **FIFO full:** i_sreq_fifo_full gates ready combinationally in the same cycle.
- **Single-flit packet** (last on the first flit): LOCKED lasts one cycle, then IDLE.

## Test plan
- **Reset values:** reset, then release → o_credits = 32, o_grant = 0, o_sreq_wen = 0, o_credit_err = 0. Assert rst_n mid-packet → the same values immediately, asynchronously.
- **Round-robin rotation:** all 4 requesters hold 3-flit packets continuously → grant order 0,1,2,3,0. Each packet takes 3 write cycles followed by 1 idle cycle. o_credits falls by 12 after one round.
- **Credit exhaustion:** requester 2 streams 40 flits with no returns → exactly 32 writes, then ready = 0 and o_credits = 0. One return pulse → 1 more write in the following cycle, and o_credits returns to 0.
- **Wormhole hold:** requester 1 owns the grant and drops valid for 5 cycles mid-packet while requester 0 is valid → o_grant stays 4'b0010 and no writes occur. Requester 1 resumes and sends its tail → the next grant goes to requester 2 if it is valid, else to requester 0.
- **Backpressure and simultaneous events:** i_sreq_fifo_full high for 3 cycles while the owner is valid → o_sreq_wen = 0 throughout and credits unchanged. A transfer and a credit return in the same cycle → o_credits unchanged.
- **Credit overflow:** with o_credits = 32 and idle, pulse i_credit_return → o_credits stays 32 and o_credit_err = 1, remaining 1 until reset.

Source files
------------

// File: rtl/credit_rr_arbiter.sv
// credit_rr_arbiter: packet-level round-robin arbiter feeding the send-request FIFO.
// One requester owns the grant from its first flit through its tail flit. Flits are
// written only while downstream credits remain. The credit counter for the request
// path lives here.
module credit_rr_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int DATA_LINE_WIDTH = 40,
   parameter int FIFO_DEPTH      = 32,
   parameter int LOG2_FIFO_DEPTH = 5,
   parameter int IDX_W           = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 i_req_valid,
   input  logic [NUM_REQ*DATA_LINE_WIDTH-1:0] i_req_bits,
   input  logic [NUM_REQ-1:0]                 i_req_last,
   output logic [NUM_REQ-1:0]                 o_req_ready,
   output logic [DATA_LINE_WIDTH-1:0]         o_sreq_inbits,
   output logic                               o_sreq_wen,
   input  logic                               i_sreq_fifo_full,
   input  logic                               i_credit_return,
   output logic [LOG2_FIFO_DEPTH:0]           o_credits,
   output logic [NUM_REQ-1:0]                 o_grant,
   output logic                               o_busy,
   output logic                               o_credit_err
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [LOG2_FIFO_DEPTH:0] CREDIT_MAX = (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH);
   localparam logic [LOG2_FIFO_DEPTH:0] CREDIT_ONE = (LOG2_FIFO_DEPTH+1)'(1);
   localparam logic [IDX_W-1:0]         LAST_IDX   = IDX_W'(NUM_REQ-1);
   localparam logic [IDX_W-1:0]         IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W:0]           NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);

   logic [0:0]               state_q, state_d;
   logic [IDX_W-1:0]         owner_q, owner_d;
   logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic [LOG2_FIFO_DEPTH:0] credits_q, credits_d;
   logic                     credit_err_q, credit_err_d;

   logic [DATA_LINE_WIDTH-1:0] flit_arr [NUM_REQ];
   logic [NUM_REQ-1:0]         owner_onehot;
   logic                       locked;
   logic                       can_send;
   logic                       xfer;
   logic                       tail;
   logic                       pick_valid;
   logic [IDX_W-1:0]           pick_idx;
   logic [IDX_W:0]             cand;

   // Split the packed flit bus into one entry per requester
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign flit_arr[gi] = i_req_bits[gi*DATA_LINE_WIDTH +: DATA_LINE_WIDTH];
      end
   endgenerate

   assign locked       = (state_q == ST_LOCKED);
   assign owner_onehot = NUM_REQ'(1) << owner_q;
   assign can_send     = (credits_q != '0) && !i_sreq_fifo_full;
   assign xfer         = locked && can_send && i_req_valid[owner_q];
   assign tail         = xfer && i_req_last[owner_q];

   assign o_grant       = locked ? owner_onehot : '0;
   assign o_req_ready   = (locked && can_send) ? owner_onehot : '0;
   assign o_sreq_wen    = xfer;
   // Zeroed when nothing is written so the FIFO data bus never floats to X
   assign o_sreq_inbits = xfer ? flit_arr[owner_q] : '0;
   assign o_credits     = credits_q;
   assign o_busy        = locked;
   assign o_credit_err  = credit_err_q;

   // Round-robin pick: scan from the highest offset down so the lowest offset from rr_ptr wins
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = rr_ptr_q;
      cand       = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= NUM_REQ_W) begin
            cand = cand - NUM_REQ_W;
         end
         if (i_req_valid[cand[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Ownership FSM: lock on a pick, release after the owner's tail flit
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_LOCKED;
               owner_d = pick_idx;
            end
         end
         default: begin
            if (tail) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_ONE;
            end
         end
      endcase
   end

   // Credit counter: a write spends one credit, a return pulse refunds one, saturating at depth
   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      case ({xfer, i_credit_return})
         2'b10: credits_d = credits_q - CREDIT_ONE;
         2'b01: begin
            if (credits_q == CREDIT_MAX) begin
               credit_err_d = 1'b1;
            end else begin
               credits_d = credits_q + CREDIT_ONE;
            end
         end
         default: credits_d = credits_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         credits_q    <= CREDIT_MAX;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_ptr_q     <= rr_ptr_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
      end
   end

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// tb_credit_rr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a packet-level reference model of the arbiter.
module tb_credit_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 40;
   localparam int D  = 32;
   localparam int LD = 5;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   i_req_valid = '0;
   logic [N*W-1:0] i_req_bits = '0;
   logic [N-1:0]   i_req_last = '0;
   logic [N-1:0]   o_req_ready;
   logic [W-1:0]   o_sreq_inbits;
   logic           o_sreq_wen;
   logic           i_sreq_fifo_full = 1'b0;
   logic           i_credit_return = 1'b0;
   logic [LD:0]    o_credits;
   logic [N-1:0]   o_grant;
   logic           o_busy;
   logic           o_credit_err;

   credit_rr_arbiter #(
      .NUM_REQ(N), .DATA_LINE_WIDTH(W), .FIFO_DEPTH(D), .LOG2_FIFO_DEPTH(LD), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_bits(i_req_bits), .i_req_last(i_req_last),
      .o_req_ready(o_req_ready), .o_sreq_inbits(o_sreq_inbits), .o_sreq_wen(o_sreq_wen),
      .i_sreq_fifo_full(i_sreq_fifo_full), .i_credit_return(i_credit_return),
      .o_credits(o_credits), .o_grant(o_grant), .o_busy(o_busy), .o_credit_err(o_credit_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // stimulus state: flits left in each requester's packet, offer enable, per-cycle data
   int         rem  [N];
   bit         en   [N];
   logic [W-1:0] flit [N];
   bit         full;
   bit         cret;

   // reference model: owner (-1 when idle), round-robin start, credit count, sticky error
   int m_owner;
   int m_rr;
   int m_cred;
   bit m_err;

   int grant_log[$];
   int wr_cnt;
   int cyc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         flit[k] = W'({$urandom(), $urandom()});
         i_req_valid[k] = (rem[k] > 0) && en[k];
         i_req_last[k]  = (rem[k] == 1);
         i_req_bits[k*W +: W] = flit[k];
      end
      i_sreq_fifo_full = full;
      i_credit_return  = cret;
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_rr    = 0;
      m_cred  = D;
      m_err   = 1'b0;
   endtask

   // one checked clock cycle: drive, compare at negedge, advance model at posedge
   task automatic step();
      bit idle, can, xfer;
      logic [N-1:0] eg;
      drive();
      @(negedge clk);
      idle = (m_owner < 0);
      can  = (m_cred != 0) && !full;
      eg   = idle ? '0 : (N'(1) << m_owner);
      xfer = 1'b0;
      if (!idle) xfer = can && (rem[m_owner] > 0) && en[m_owner];
      chk("grant",   o_grant, eg);
      chk("ready",   o_req_ready, can ? eg : '0);
      chk("wen",     o_sreq_wen, xfer);
      chk("credits", o_credits, m_cred);
      chk("busy",    o_busy, !idle);
      chk("err",     o_credit_err, m_err);
      if (xfer) begin
         chk("data", o_sreq_inbits, flit[m_owner]);
         $display("xfer req=%0d last=%0d data=%h credits=%0d", m_owner, rem[m_owner] == 1,
                  flit[m_owner], m_cred);
      end
      if (o_sreq_wen) wr_cnt++;
      @(posedge clk);
      if (idle) begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (rem[c] > 0 && en[c]) begin
               m_owner = c;
               grant_log.push_back(c);
               break;
            end
         end
      end else if (xfer) begin
         rem[m_owner]--;
         if (rem[m_owner] == 0) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
         end
      end
      m_cred = m_cred - int'(xfer) + int'(cret);
      if (m_cred > D) begin
         m_cred = D;
         m_err  = 1'b1;
      end
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         rem[k] = 0;
         en[k]  = 1'b1;
      end
      full = 1'b0;
      cret = 1'b0;
      drive();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      // reset values
      do_reset();
      chk("rst_credits", o_credits, D);
      chk("rst_grant",   o_grant, 0);
      chk("rst_wen",     o_sreq_wen, 0);
      chk("rst_err",     o_credit_err, 0);
      chk("rst_busy",    o_busy, 0);

      // round robin with continuous 3-flit packets
      grant_log.delete();
      cyc = 0;
      while (grant_log.size() < 5 && cyc < 40) begin
         for (int k = 0; k < N; k++) if (rem[k] == 0) rem[k] = 3;
         step();
      end
      chk("rr_cycles", cyc, 17);
      chk("rr_credits", o_credits, D - 12);
      for (int i = 0; i < 5; i++) chk("rr_order", (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);

      // asynchronous reset mid-packet
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_credits", o_credits, D);
      chk("arst_grant",   o_grant, 0);
      chk("arst_wen",     o_sreq_wen, 0);
      chk("arst_busy",    o_busy, 0);
      chk("arst_err",     o_credit_err, 0);
      do_reset();

      // credit exhaustion on requester 2
      rem[2] = 40;
      wr_cnt = 0;
      repeat (40) step();
      chk("exh_writes",  wr_cnt, 32);
      chk("exh_credits", o_credits, 0);
      chk("exh_ready",   o_req_ready, 0);
      cret = 1'b1;
      step();
      cret = 1'b0;
      wr_cnt = 0;
      step();
      chk("exh_one_more", wr_cnt, 1);
      chk("exh_zero_again", o_credits, 0);
      do_reset();

      // wormhole hold: requester 1 stalls mid-packet
      rem[1] = 4;
      en[0] = 1'b0;
      repeat (3) step();
      en[0] = 1'b1;
      en[1] = 1'b0;
      rem[0] = 2;
      rem[2] = 1;
      wr_cnt = 0;
      repeat (5) begin
         step();
         chk("wh_grant", o_grant, 4'b0010);
      end
      chk("wh_no_writes", wr_cnt, 0);
      en[1] = 1'b1;
      grant_log.delete();
      repeat (3) step();
      chk("wh_next_owner", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
      chk("wh_next_grant", o_grant, 4'b0100);
      do_reset();

      // backpressure from a full FIFO, then write and return together
      rem[3] = 10;
      repeat (2) step();
      full = 1'b1;
      wr_cnt = 0;
      repeat (3) step();
      chk("bp_no_writes", wr_cnt, 0);
      chk("bp_credits", o_credits, D - 1);
      full = 1'b0;
      cret = 1'b1;
      step();
      cret = 1'b0;
      chk("simul_writes", wr_cnt, 1);
      chk("simul_credits", o_credits, D - 1);
      do_reset();

      // credit overflow while idle
      cret = 1'b1;
      step();
      cret = 1'b0;
      chk("ovf_credits", o_credits, D);
      chk("ovf_err", o_credit_err, 1);
      repeat (5) step();
      chk("ovf_sticky", o_credit_err, 1);
      do_reset();
      chk("ovf_cleared", o_credit_err, 0);

      // randomized traffic
      repeat (3000) begin
         for (int k = 0; k < N; k++) begin
            if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 6);
            en[k] = ($urandom_range(0, 4) != 0);
         end
         full = ($urandom_range(0, 5) == 0);
         cret = (m_cred < D) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
